// File: rtl/led_status_ctrl.sv
// led_status_ctrl: multi-channel LED status driver (off / steady / shared-phase blink / numeric blink code).
// Define LED_PWM_DIM_EN to gate every lit channel with a global PWM brightness ("dim").
module led_status_ctrl #(
  parameter int unsigned N_LED       = 4,
  parameter int unsigned HALF_TICKS  = 25_000_000,
  parameter int unsigned CODE_W      = 3,
  parameter int unsigned PAUSE_TICKS = 4,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*N_LED-1:0]        mode,
  input  logic [CODE_W*N_LED-1:0]   code,
  input  logic [PWM_BITS-1:0]       dim,
  output logic [N_LED-1:0]          led,
  output logic                      tick
);

  localparam int unsigned PRE_W  = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
  localparam int unsigned QCNT_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(HALF_TICKS - 1);
  localparam logic [QCNT_W-1:0] Q_LAST   = QCNT_W'(PAUSE_TICKS - 1);

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_PAUSE} state_t;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              blink_q, blink_d;
  logic              tick_d;

  logic [1:0]        mode_ch [N_LED];
  logic [CODE_W-1:0] code_ch [N_LED];

  state_t            state_q [N_LED];
  state_t            state_d [N_LED];
  logic [CODE_W-1:0] code_q  [N_LED];
  logic [CODE_W-1:0] code_d  [N_LED];
  logic [CODE_W-1:0] pcnt_q  [N_LED];
  logic [CODE_W-1:0] pcnt_d  [N_LED];
  logic [QCNT_W-1:0] qcnt_q  [N_LED];
  logic [QCNT_W-1:0] qcnt_d  [N_LED];

  logic [N_LED-1:0]  lit_d;
  logic [N_LED-1:0]  led_d;
  logic              en_c;

  // Shared timebase; tick register is high exactly while the prescaler sits at its last count.
  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    tick_d  = (presc_d == PRE_LAST);
    blink_d = tick ? ~blink_q : blink_q;
  end

  always_comb begin
    for (int i = 0; i < int'(N_LED); i++) begin
      mode_ch[i] = mode[2*i +: 2];
      code_ch[i] = code[CODE_W*i +: CODE_W];
    end
  end

  // Per-channel code sequencer; leaving mode 11 aborts immediately, everything else waits for tick.
  always_comb begin
    for (int i = 0; i < int'(N_LED); i++) begin
      state_d[i] = state_q[i];
      code_d[i]  = code_q[i];
      pcnt_d[i]  = pcnt_q[i];
      qcnt_d[i]  = qcnt_q[i];
      if (mode_ch[i] != 2'b11) begin
        state_d[i] = S_IDLE;
      end else if (tick) begin
        unique case (state_q[i])
          S_IDLE: begin
            if (code_ch[i] != '0) begin
              code_d[i]  = code_ch[i];
              pcnt_d[i]  = CODE_W'(1);
              state_d[i] = S_ON;
            end
          end
          S_ON: begin
            state_d[i] = S_OFF;
          end
          S_OFF: begin
            if (pcnt_q[i] == code_q[i]) begin
              qcnt_d[i]  = '0;
              state_d[i] = S_PAUSE;
            end else begin
              pcnt_d[i]  = pcnt_q[i] + CODE_W'(1);
              state_d[i] = S_ON;
            end
          end
          S_PAUSE: begin
            if (qcnt_q[i] == Q_LAST) begin
              if (code_ch[i] != '0) begin
                code_d[i]  = code_ch[i];
                pcnt_d[i]  = CODE_W'(1);
                state_d[i] = S_ON;
              end else begin
                state_d[i] = S_IDLE;
              end
            end else begin
              qcnt_d[i] = qcnt_q[i] + QCNT_W'(1);
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // Drive values are taken from next-cycle state so led lines up with blink_q / state_q.
  always_comb begin
    lit_d = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      case (mode_ch[i])
        M_OFF:   lit_d[i] = 1'b0;
        M_ON:    lit_d[i] = 1'b1;
        M_BLINK: lit_d[i] = blink_d;
        default: lit_d[i] = (state_d[i] == S_ON);
      endcase
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_q;

  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_q + PWM_BITS'(1);
  end

  assign en_c = (dim == {PWM_BITS{1'b1}}) || (pwm_q < dim);
`else
  logic unused_dim;
  assign unused_dim = ^dim;
  assign en_c       = 1'b1;
`endif

  assign led_d = lit_d & {N_LED{en_c}};

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      blink_q <= 1'b0;
      tick    <= 1'b0;
      led     <= '0;
      for (int i = 0; i < int'(N_LED); i++) begin
        state_q[i] <= S_IDLE;
        code_q[i]  <= '0;
        pcnt_q[i]  <= '0;
        qcnt_q[i]  <= '0;
      end
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      tick    <= tick_d;
      led     <= led_d;
      for (int i = 0; i < int'(N_LED); i++) begin
        state_q[i] <= state_d[i];
        code_q[i]  <= code_d[i];
        pcnt_q[i]  <= pcnt_d[i];
        qcnt_q[i]  <= qcnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Bench for led_status_ctrl: scenario tasks against a tick-slot reference model of each channel.
// Dimming scenario switches on LED_PWM_DIM_EN, matching the design build.
module tb_led_status_ctrl;

  localparam int NL = 4;
  localparam int HT = 4;
  localparam int CW = 3;
  localparam int PT = 3;
  localparam int PB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [2*NL-1:0] mode;
  logic [CW*NL-1:0] code;
  logic [PB-1:0]   dim;
  logic [NL-1:0]   led;
  logic            tick;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  led_status_ctrl #(
    .N_LED(NL), .HALF_TICKS(HT), .CODE_W(CW), .PAUSE_TICKS(PT), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .code(code), .dim(dim), .led(led), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference: each code channel walks a slot index through ON/OFF pairs then the pause, one slot per tick.
  int unsigned m_edges;
  logic        m_bp;
  int          m_pos [NL];
  int          m_k   [NL];
  logic [NL-1:0] exp_led;
  logic        exp_tick;
  logic        m_tk, m_en;
  int          m_mode, m_code, m_len;

  always @(posedge clk) begin
    if (rst) begin
      m_edges = 0;
      m_bp = 1'b0;
      for (int i = 0; i < NL; i++) begin m_pos[i] = 0; m_k[i] = 0; end
      exp_led = '0;
      exp_tick = 1'b0;
    end else begin
      m_tk = ((m_edges % HT) == HT - 1);
      m_en = 1'b1;
`ifdef LED_PWM_DIM_EN
      m_en = (dim == 4'hF) || ((m_edges % 16) < dim);
`endif
      if (m_tk) m_bp = ~m_bp;
      for (int i = 0; i < NL; i++) begin
        m_mode = int'(mode[2*i +: 2]);
        m_code = int'(code[CW*i +: CW]);
        if (m_mode != 3) begin
          m_pos[i] = 0;
        end else if (m_tk) begin
          m_len = 2 * m_k[i] + PT;
          if (m_pos[i] == 0 || m_pos[i] == m_len) begin
            if (m_code != 0) begin m_k[i] = m_code; m_pos[i] = 1; end
            else m_pos[i] = 0;
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end
        case (m_mode)
          0: exp_led[i] = 1'b0;
          1: exp_led[i] = m_en;
          2: exp_led[i] = m_bp & m_en;
          default: exp_led[i] = (m_pos[i] != 0) && (m_pos[i] <= 2 * m_k[i]) && (m_pos[i] % 2 == 1) && m_en;
        endcase
      end
      m_edges = m_edges + 1;
      exp_tick = ((m_edges % HT) == HT - 1);
    end
  end

  task automatic test_reset();
    rst = 1'b1; mode = '0; code = '0; dim = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (led !== 4'b0000 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: led=%b tick=%b expected led=0000 tick=0", led, tick);
    end
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      vectors++;
      if (tick !== (k % 4 == 0) || led !== 4'b0000) begin
        miscompares++;
        $display("FAIL tick_cadence k=%0d: tick=%b led=%b expected tick=%b led=0000", k, tick, led, (k % 4 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_steady_blink();
    int highs, toggles;
    logic prev;
    mode[1:0] = 2'b01;
    mode[3:2] = 2'b10;
    @(negedge clk);
    vectors++;
    if (led[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL steady_latency: led0=%b expected 1", led[0]);
    end
    repeat (9) @(negedge clk);
    mode[7:6] = 2'b10;
    highs = 0; toggles = 0; prev = led[1];
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led || tick !== exp_tick || led[3] !== led[1]) begin
        miscompares++;
        $display("FAIL blink_model: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
      end
      if (led[1] !== prev) toggles++;
      if (led[1] === 1'b1) highs++;
      prev = led[1];
    end
    vectors++;
    if (highs != 8 || toggles != 4) begin
      miscompares++;
      $display("FAIL blink_duty: highs=%0d toggles=%0d expected 8 and 4", highs, toggles);
    end
  endtask

  task automatic test_code3();
    int highs, rises;
    logic prev;
    mode[5:4] = 2'b11;
    code[8:6] = 3'd3;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        miscompares++;
        $display("FAIL code3_model: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
      end
    end
    highs = 0; rises = 0; prev = led[2];
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      if (led[2] === 1'b1 && prev === 1'b0) rises++;
      if (led[2] === 1'b1) highs++;
      prev = led[2];
    end
    vectors++;
    if (highs != 12 || rises != 3) begin
      miscompares++;
      $display("FAIL code3_period: highs=%0d rises=%0d expected 12 and 3", highs, rises);
    end
  endtask

  task automatic test_code_change();
    int cnt [3];
    int seq, dark, guard;
    logic prev;
    mode[7:6] = 2'b00;
    @(negedge clk);
    mode[7:6] = 2'b11;
    code[11:9] = 3'd7;
    prev = 1'b0; cnt[0] = 0; cnt[1] = 0; cnt[2] = 0; guard = 0;
    while (cnt[0] < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (led[3] === 1'b1 && prev === 1'b0) cnt[0]++;
      prev = led[3];
    end
    code[11:9] = 3'd2;
    seq = 0; dark = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        miscompares++;
        $display("FAIL code_change_model: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
      end
      if (led[3] === 1'b1 && prev === 1'b0) begin
        if (dark > 8) seq++;
        if (seq < 3) cnt[seq]++;
      end
      dark = (led[3] === 1'b1) ? 0 : dark + 1;
      prev = led[3];
    end
    vectors++;
    if (cnt[0] != 7 || cnt[1] != 2 || cnt[2] != 2) begin
      miscompares++;
      $display("FAIL code_change_pulses: got %0d,%0d,%0d expected 7,2,2", cnt[0], cnt[1], cnt[2]);
    end
    guard = 0;
    while (led[3] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    mode[7:6] = 2'b00;
    @(negedge clk);
    vectors++;
    if (led[3] !== 1'b0 || guard >= 100) begin
      miscompares++;
      $display("FAIL abort_mid_on: led3=%b wait=%0d expected led3=0 within 100", led[3], guard);
    end
    mode[7:6] = 2'b11;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        miscompares++;
        $display("FAIL restart_after_abort: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (led[2] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (led !== 4'b0000 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: led=%b tick=%b expected led=0000 tick=0", led, tick);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (led[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_first_pulse: led2=%b expected 1", led[2]);
    end
    mode[3:2] = 2'b11;
    code[5:3] = 3'd0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led || tick !== exp_tick || led[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL code0_dark: led=%b tick=%b expected led=%b tick=%b", led, tick, exp_led, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    int ch, mv;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        ch = int'($urandom_range(0, NL - 1));
        mv = int'($urandom_range(0, 5));
        mode[2*ch +: 2] = 2'((mv > 3) ? 3 : mv);
        code[CW*ch +: CW] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) begin
        ch = int'($urandom_range(0, NL - 1));
        code[CW*ch +: CW] = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 31) == 0) dim = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      vectors++;
      if (led !== exp_led || tick !== exp_tick) begin
        miscompares++;
        $display("FAIL random n=%0d: led=%b tick=%b expected led=%b tick=%b", n, led, tick, exp_led, exp_tick);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_dim();
    int highs;
    mode = '0;
    mode[1:0] = 2'b01;
`ifdef LED_PWM_DIM_EN
    for (int d = 0; d < 3; d++) begin
      dim = (d == 0) ? 4'd4 : (d == 1) ? 4'd15 : 4'd0;
      @(negedge clk);
      highs = 0;
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        vectors++;
        if (led !== exp_led) begin
          miscompares++;
          $display("FAIL dim_model: led=%b expected %b dim=%0d", led, exp_led, dim);
        end
        if (led[0] === 1'b1) highs++;
      end
      vectors++;
      if (highs != ((d == 0) ? 4 : (d == 1) ? 16 : 0)) begin
        miscompares++;
        $display("FAIL dim_duty dim=%0d: highs=%0d expected %0d", dim, highs, (d == 0) ? 4 : (d == 1) ? 16 : 0);
      end
    end
`else
    for (int n = 0; n < 16; n++) begin
      dim = 4'($urandom_range(0, 15));
      @(negedge clk);
      vectors++;
      if (led[0] !== 1'b1 || led !== exp_led) begin
        miscompares++;
        $display("FAIL dim_ignored: led=%b expected %b", led, exp_led);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_steady_blink();
    test_code3();
    test_code_change();
    test_reset_mid();
    test_random();
    test_dim();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
